// File: rtl/dispatch_queue.sv
// dispatch_queue
//   In-order dispatch buffer between the decoder and the out-of-order core.
//   Decode bundles are written into a circular queue. Each cycle the queue
//   releases as many head entries as the ROB, RS and SQ can accept. A stall
//   in one structure therefore only trims the released prefix and does not
//   block the whole bundle.
//
// Ports
//   clock        : single clock, rising edge
//   reset_n      : asynchronous active-low reset (clears pointers and count)
//   squash       : synchronous flush on mispredict; wins over everything
//   in_valid     : decode lane valids; only the leading-ones prefix counts
//   in_data      : lane payloads, lane 0 oldest
//   in_is_store  : lane needs an SQ slot
//   in_ready     : the whole bundle is accepted this cycle
//   rob_free     : ROB slots available this cycle (saturated to WIDTH)
//   rs_free      : RS slots available this cycle (saturated to WIDTH)
//   sq_free      : SQ slots available this cycle (saturated to WIDTH)
//   out_valid    : dispatched lanes, always a prefix
//   out_data     : head entries, lane 0 oldest, driven regardless of validity
//   out_is_store : store flag of each out lane
//   count        : registered occupancy
//
// Handshake: a bundle transfers on a rising edge where in_ready is 1. The
// accepted lanes are the leading-ones prefix of in_valid. in_ready depends
// only on the registered count and on squash, never on in_valid. On the
// output side there is no back-pressure. out_valid is itself the dispatch
// event. The consumer has already granted credits through *_free, so every
// lane with out_valid set is removed from the queue on the next edge.
module dispatch_queue #(
  parameter int WIDTH   = 3,
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 64,
  parameter int CW      = $clog2(WIDTH + 1),
  parameter int QW      = $clog2(DEPTH + 1)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       squash,
  input  logic [WIDTH-1:0]           in_valid,
  input  logic [WIDTH*ENTRY_W-1:0]   in_data,
  input  logic [WIDTH-1:0]           in_is_store,
  output logic                       in_ready,
  input  logic [CW-1:0]              rob_free,
  input  logic [CW-1:0]              rs_free,
  input  logic [CW-1:0]              sq_free,
  output logic [WIDTH-1:0]           out_valid,
  output logic [WIDTH*ENTRY_W-1:0]   out_data,
  output logic [WIDTH-1:0]           out_is_store,
  output logic [QW-1:0]              count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  logic [ENTRY_W-1:0] mem_data  [DEPTH];
  logic               mem_store [DEPTH];

  logic [PW-1:0]      rd_idx [WIDTH];
  logic [PW-1:0]      wr_idx [WIDTH];
  int                 e_n;   // lanes enqueued this cycle
  int                 k_n;   // lanes dispatched this cycle

  // The offset is never larger than DEPTH, so one conditional subtract is
  // enough to wrap. This also keeps non-power-of-two depths legal.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                              input int off);
    int s;
    s = int'(base) + off;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  function automatic int sat(input logic [CW-1:0] v);
    return (int'(v) > WIDTH) ? WIDTH : int'(v);
  endfunction

  // The registered count is used without crediting a same-cycle dequeue.
  // This keeps in_ready off the *_free to dispatch path.
  assign in_ready = ((DEPTH - int'(count)) >= WIDTH) && !squash;

  always_comb begin
    int  lim;
    int  stores;
    logic run;
    for (int i = 0; i < WIDTH; i++) begin
      rd_idx[i] = wrap_add(head, i);
      wr_idx[i] = wrap_add(tail, i);
    end

    // Enqueue takes the leading-ones prefix of in_valid.
    e_n = 0;
    run = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (run && in_valid[i]) e_n = i + 1;
      else                    run = 1'b0;
    end
    if (!in_ready) e_n = 0;

    // Dispatch takes the longest head prefix that fits the ROB and RS limits
    // and whose store count fits sq_free. The cumulative store count never
    // decreases, so the first lane that fails ends the prefix.
    lim = int'(count);
    if (lim > WIDTH)          lim = WIDTH;
    if (sat(rob_free) < lim)  lim = sat(rob_free);
    if (sat(rs_free) < lim)   lim = sat(rs_free);
    k_n    = 0;
    stores = 0;
    run    = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (mem_store[rd_idx[i]]) stores = stores + 1;
      if (run && (i < lim) && (stores <= sat(sq_free))) k_n = i + 1;
      else                                                run = 1'b0;
    end
    if (squash) k_n = 0;

    out_valid    = '0;
    out_data     = '0;
    out_is_store = '0;
    for (int i = 0; i < WIDTH; i++) begin
      out_valid[i]                       = (i < k_n);
      out_data[i*ENTRY_W +: ENTRY_W]     = mem_data[rd_idx[i]];
      out_is_store[i]                    = mem_store[rd_idx[i]];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= wrap_add(head, k_n);
      tail  <= wrap_add(tail, e_n);
      count <= QW'(int'(count) + e_n - k_n);
    end
  end

  // Payload storage is not reset. Slots outside [head, head+count) are never
  // reported as valid.
  always_ff @(posedge clock) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (i < e_n) begin
        mem_data[wr_idx[i]]  <= in_data[i*ENTRY_W +: ENTRY_W];
        mem_store[wr_idx[i]] <= in_is_store[i];
      end
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
module tb_dispatch_queue;
  localparam int WIDTH = 3;
  localparam int DEPTH = 6;
  localparam int EW    = 16;
  localparam int CW    = $clog2(WIDTH + 1);
  localparam int QW    = $clog2(DEPTH + 1);

  // ---------------- clock / reset and DUT ----------------
  logic                 clock = 1'b0;
  logic                 reset_n;
  logic                 squash;
  logic [WIDTH-1:0]     in_valid;
  logic [WIDTH*EW-1:0]  in_data;
  logic [WIDTH-1:0]     in_is_store;
  logic                 in_ready;
  logic [CW-1:0]        rob_free, rs_free, sq_free;
  logic [WIDTH-1:0]     out_valid;
  logic [WIDTH*EW-1:0]  out_data;
  logic [WIDTH-1:0]     out_is_store;
  logic [QW-1:0]        count;

  always #5 clock = ~clock;

  dispatch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ENTRY_W(EW)) dut (
    .clock(clock), .reset_n(reset_n), .squash(squash),
    .in_valid(in_valid), .in_data(in_data), .in_is_store(in_is_store),
    .in_ready(in_ready), .rob_free(rob_free), .rs_free(rs_free),
    .sq_free(sq_free), .out_valid(out_valid), .out_data(out_data),
    .out_is_store(out_is_store), .count(count)
  );

  int vectors     = 0;
  int miscompares = 0;
  int next_tag    = 0;

  // ---------------- reference model: queue of {data, is_store} -------------
  logic [EW:0] exp_q[$];

  function automatic int sat_m(input logic [CW-1:0] v);
    return (int'(v) > WIDTH) ? WIDTH : int'(v);
  endfunction

  function automatic bit model_ready();
    return !squash && ((DEPTH - exp_q.size()) >= WIDTH);
  endfunction

  function automatic int model_e();
    int e = 0;
    if (!model_ready()) return 0;
    while (e < WIDTH && in_valid[e]) e++;
    return e;
  endfunction

  function automatic int model_k();
    int lim, st, k;
    if (squash) return 0;
    lim = exp_q.size();
    if (lim > WIDTH) lim = WIDTH;
    if (sat_m(rob_free) < lim) lim = sat_m(rob_free);
    if (sat_m(rs_free)  < lim) lim = sat_m(rs_free);
    st = 0;
    k  = 0;
    for (int i = 0; i < lim; i++) begin
      if (exp_q[i][0]) st++;
      if (st > sat_m(sq_free)) break;
      k = i + 1;
    end
    return k;
  endfunction

  function automatic logic [EW-1:0] lane_data(input int i);
    return out_data[i*EW +: EW];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] st);
    in_valid    = v;
    in_is_store = st;
    for (int i = 0; i < WIDTH; i++) in_data[i*EW +: EW] = EW'(next_tag + i);
  endtask

  task automatic frees(input int rob, input int rs, input int sq);
    rob_free = CW'(rob);
    rs_free  = CW'(rs);
    sq_free  = CW'(sq);
  endtask

  // Apply the model's view of the coming edge, then advance to just after it.
  task automatic tick();
    int k, e;
    k = model_k();
    e = model_e();
    if (squash) exp_q.delete();
    else begin
      for (int i = 0; i < k; i++) void'(exp_q.pop_front());
      for (int i = 0; i < e; i++) exp_q.push_back({in_data[i*EW +: EW], in_is_store[i]});
      next_tag += e;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    drive('0, '0);
    frees(3, 3, 3);
    for (int n = 0; n < 12 && exp_q.size() != 0; n++) tick();
    #1;
    vectors++;
    if (count !== '0) begin
      miscompares++;
      $display("FAIL drain_count got %0d want 0", count);
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    squash  = 1'b0;
    drive('0, '0);
    frees(3, 3, 3);
    #2;
    vectors++;
    if (count !== '0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
    vectors++;
    if (out_valid !== '0) begin miscompares++; $display("FAIL reset_out_valid got %b want 000", out_valid); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_fill();
    int want_cnt [4] = '{0, 3, 6, 6};
    bit want_rdy [4] = '{1, 1, 0, 0};
    frees(0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      drive('1, '0);
      #1;
      vectors++;
      if (count !== QW'(want_cnt[c])) begin
        miscompares++; $display("FAIL fill_count c%0d got %0d want %0d", c, count, want_cnt[c]);
      end
      vectors++;
      if (in_ready !== want_rdy[c]) begin
        miscompares++; $display("FAIL fill_in_ready c%0d got %b want %b", c, in_ready, want_rdy[c]);
      end
      vectors++;
      if (out_valid !== '0) begin
        miscompares++; $display("FAIL fill_out_valid c%0d got %b want 000", c, out_valid);
      end
      tick();
    end
  endtask

  task automatic test_partial();
    logic [EW-1:0] third;
    third = exp_q[2][EW:1];
    drive('0, '0);
    frees(3, 2, 3);
    #1;
    vectors++;
    if (out_valid !== 3'b011) begin miscompares++; $display("FAIL partial_out_valid got %b want 011", out_valid); end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (lane_data(i) !== exp_q[i][EW:1]) begin
        miscompares++; $display("FAIL partial_data lane%0d got %0h want %0h", i, lane_data(i), exp_q[i][EW:1]);
      end
    end
    tick();
    frees(0, 0, 0);
    #1;
    vectors++;
    if (count !== QW'(4)) begin miscompares++; $display("FAIL partial_count got %0d want 4", count); end
    vectors++;
    if (lane_data(0) !== third) begin miscompares++; $display("FAIL partial_head got %0h want %0h", lane_data(0), third); end
    drain();
  endtask

  task automatic test_store_limit();
    frees(0, 0, 0);
    drive('1, 3'b101);
    tick();
    drive('0, '0);
    frees(3, 3, 1);
    #1;
    vectors++;
    if (out_valid !== 3'b011) begin miscompares++; $display("FAIL store_sq1_a got %b want 011", out_valid); end
    vectors++;
    if (out_is_store[1:0] !== 2'b01) begin miscompares++; $display("FAIL store_flags got %b want 01", out_is_store[1:0]); end
    tick();
    #1;
    vectors++;
    if (out_valid !== 3'b001) begin miscompares++; $display("FAIL store_sq1_b got %b want 001", out_valid); end
    vectors++;
    if (out_is_store[0] !== 1'b1) begin miscompares++; $display("FAIL store_lane0 got %b want 1", out_is_store[0]); end
    tick();
    // sq_free = 0 still releases the non-store prefix.
    frees(0, 0, 0);
    drive('1, 3'b100);
    tick();
    drive('0, '0);
    frees(3, 3, 0);
    #1;
    vectors++;
    if (out_valid !== 3'b011) begin miscompares++; $display("FAIL store_sq0_prefix got %b want 011", out_valid); end
    tick();
    #1;
    vectors++;
    if (out_valid !== 3'b000) begin miscompares++; $display("FAIL store_sq0_block got %b want 000", out_valid); end
    frees(0, 3, 3);
    #1;
    vectors++;
    if (out_valid !== 3'b000) begin miscompares++; $display("FAIL rob0_block got %b want 000", out_valid); end
    frees(3, 3, 1);
    #1;
    vectors++;
    if (out_valid !== 3'b001) begin miscompares++; $display("FAIL store_release got %b want 001", out_valid); end
    tick();
    drain();
  endtask

  task automatic test_squash();
    logic [EW-1:0] tag;
    frees(0, 0, 0);
    drive('1, '0);
    tick();
    drive(3'b001, '0);
    tick();
    drive('1, '0);
    frees(3, 3, 3);
    squash = 1'b1;
    #1;
    vectors++;
    if (out_valid !== '0) begin miscompares++; $display("FAIL squash_out_valid got %b want 000", out_valid); end
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL squash_in_ready got %b want 0", in_ready); end
    tick();
    squash = 1'b0;
    drive(3'b001, '0);
    tag = EW'(next_tag);
    #1;
    vectors++;
    if (count !== '0) begin miscompares++; $display("FAIL squash_count got %0d want 0", count); end
    vectors++;
    if (out_valid !== '0) begin miscompares++; $display("FAIL squash_no_bypass got %b want 000", out_valid); end
    tick();
    drive('0, '0);
    #1;
    vectors++;
    if (out_valid !== 3'b001) begin miscompares++; $display("FAIL squash_new got %b want 001", out_valid); end
    vectors++;
    if (lane_data(0) !== tag) begin miscompares++; $display("FAIL squash_new_data got %0h want %0h", lane_data(0), tag); end
    tick();
    drain();
  endtask

  task automatic test_back_to_back();
    frees(3, 3, 3);
    for (int c = 0; c < 6; c++) begin
      drive('1, '0);
      #1;
      if (c > 0) begin
        vectors++;
        if (out_valid !== 3'b111 || in_ready !== 1'b1) begin
          miscompares++; $display("FAIL b2b c%0d got valid %b ready %b want 111 1", c, out_valid, in_ready);
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    frees(0, 0, 0);
    drive('1, '0);
    tick();
    drive(3'b011, '0);
    tick();
    drive('0, '0);
    frees(3, 3, 3);
    #1;
    vectors++;
    if (count !== QW'(5)) begin miscompares++; $display("FAIL rstmid_pre got %0d want 5", count); end
    #1;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    vectors++;
    if (count !== '0 || out_valid !== '0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_async got count %0d valid %b ready %b want 0 000 1", count, out_valid, in_ready);
    end
    reset_n = 1'b1;
    tick();
    #1;
    vectors++;
    if (count !== '0 || out_valid !== '0) begin
      miscompares++; $display("FAIL rstmid_after got count %0d valid %b want 0 000", count, out_valid);
    end
  endtask

  task automatic test_random();
    int k;
    logic [WIDTH-1:0] ev;
    for (int n = 0; n < 300; n++) begin
      drive(WIDTH'($urandom), WIDTH'($urandom));
      frees($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      squash = ($urandom_range(0, 15) == 0);
      #1;
      k  = model_k();
      ev = WIDTH'((1 << k) - 1);
      vectors++;
      if (out_valid !== ev) begin miscompares++; $display("FAIL rnd_valid n%0d got %b want %b", n, out_valid, ev); end
      vectors++;
      if (in_ready !== model_ready()) begin
        miscompares++; $display("FAIL rnd_ready n%0d got %b want %b", n, in_ready, model_ready());
      end
      vectors++;
      if (count !== QW'(exp_q.size()) || int'(count) > DEPTH) begin
        miscompares++; $display("FAIL rnd_count n%0d got %0d want %0d", n, count, exp_q.size());
      end
      for (int i = 0; i < k; i++) begin
        vectors++;
        if ({lane_data(i), out_is_store[i]} !== exp_q[i]) begin
          miscompares++;
          $display("FAIL rnd_order n%0d lane%0d got %0h/%b want %0h/%b", n, i,
                   lane_data(i), out_is_store[i], exp_q[i][EW:1], exp_q[i][0]);
        end
      end
      tick();
    end
    squash = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_partial();
    test_store_limit();
    test_squash();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

endmodule
